// File: rtl/tl_rom_adapter_pkg.sv
// TileLink opcode encodings and sizing helpers shared by the ROM adapter files.
// Pure types/functions: no timing, no flow control.
package tl_rom_adapter_pkg;

  localparam int unsigned SizeWidth = 3;

  typedef enum logic [2:0] {
    A_PUT_FULL      = 3'd0,
    A_PUT_PARTIAL   = 3'd1,
    A_ARITH         = 3'd2,
    A_LOGICAL       = 3'd3,
    A_GET           = 3'd4,
    A_INTENT        = 3'd5,
    A_ACQUIRE_BLOCK = 3'd6,
    A_ACQUIRE_PERM  = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } tl_d_op_e;

  // log2 of the beat count for a transfer of 2**size bytes on a 2**lg_bytes bus.
  function automatic logic [SizeWidth-1:0] beats_log2(input logic [SizeWidth-1:0] size,
                                                      input int unsigned lg_bytes);
    logic [SizeWidth-1:0] lg;
    lg = SizeWidth'(lg_bytes);
    return (size > lg) ? size - lg : '0;
  endfunction

endpackage

// File: rtl/tl_rom_resp_buffer.sv
// Two-entry response FIFO for ROM words; zero-latency occupancy output, push/pop in one cycle.
// Backpressure: in_rdy drops only when full and the head is not being popped.
module tl_rom_resp_buffer #(
  parameter int unsigned Width = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [Width-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [Width-1:0] out_dat,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign out_vld = (cnt_q != 2'd0);
  assign in_rdy  = (cnt_q != 2'd2) | out_rdy;
  assign out_dat = mem_q[rd_ptr_q];
  assign occ_o   = cnt_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tl_rom_adapter.sv
// TL-UH device port onto a synchronous ROM: Gets become AccessAckData bursts, everything else is denied.
// Latency 2 cycles A->first D, then 1 beat/cycle; host_d_ready stalls ROM reads through a 2-credit gate.
module tl_rom_adapter
  import tl_rom_adapter_pkg::*;
#(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned AddrWidth    = 56,
  parameter int unsigned SourceWidth  = 2,
  parameter int unsigned MaxSize      = 6,
  parameter int unsigned RomAddrWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    host_a_valid,
  output logic                    host_a_ready,
  input  logic [2:0]              host_a_opcode,
  input  logic [2:0]              host_a_param,
  input  logic [SizeWidth-1:0]    host_a_size,
  input  logic [SourceWidth-1:0]  host_a_source,
  input  logic [AddrWidth-1:0]    host_a_address,
  input  logic [DataWidth/8-1:0]  host_a_mask,
  input  logic                    host_a_corrupt,
  input  logic [DataWidth-1:0]    host_a_data,
  output logic                    host_d_valid,
  input  logic                    host_d_ready,
  output logic [2:0]              host_d_opcode,
  output logic [1:0]              host_d_param,
  output logic [SizeWidth-1:0]    host_d_size,
  output logic [SourceWidth-1:0]  host_d_source,
  output logic                    host_d_sink,
  output logic                    host_d_denied,
  output logic [DataWidth-1:0]    host_d_data,
  output logic                    host_d_corrupt,
  output logic                    host_b_valid,
  output logic                    host_c_ready,
  output logic                    host_e_ready,
  output logic                    rom_req_o,
  output logic [RomAddrWidth-1:0] rom_addr_o,
  input  logic [DataWidth-1:0]    rom_rdata_i
);

  localparam int unsigned LgBytes   = $clog2(DataWidth / 8);
  localparam int unsigned BeatWidth = (MaxSize > LgBytes + 1) ? MaxSize - LgBytes : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_SINK, ST_ERR} state_e;

  state_e                  state_q, state_d;
  logic [SizeWidth-1:0]    size_q, size_d;
  logic [SourceWidth-1:0]  source_q, source_d;
  logic [2:0]              op_q, op_d;
  logic [RomAddrWidth-1:0] base_q, base_d;
  logic [BeatWidth-1:0]    last_q, last_d;
  logic [BeatWidth-1:0]    beat_q, beat_d;
  logic                    req_done_q, req_done_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;

  logic                    buf_in_rdy, buf_out_vld, buf_out_rdy, buf_out_last;
  logic [DataWidth-1:0]    buf_out_data;
  logic [1:0]              buf_occ;
  logic [BeatWidth-1:0]    a_last_idx, err_last;
  logic [2:0]              used;
  logic                    pop;

  tl_rom_resp_buffer #(.Width(DataWidth + 1)) u_resp_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_vld  (inflight_q),
    .in_rdy  (buf_in_rdy),
    .in_dat  ({rom_rdata_i, inflight_last_q}),
    .out_vld (buf_out_vld),
    .out_rdy (buf_out_rdy),
    .out_dat ({buf_out_data, buf_out_last}),
    .occ_o   (buf_occ)
  );

  assign a_last_idx = BeatWidth'((32'd1 << beats_log2(host_a_size, LgBytes)) - 32'd1);
  assign err_last   = (op_q == A_ARITH || op_q == A_LOGICAL) ? last_q : '0;
  assign used       = {1'b0, buf_occ} + {2'b0, inflight_q};
  assign pop        = buf_out_vld & host_d_ready;

  assign host_b_valid = 1'b0;
  assign host_c_ready = 1'b1;
  assign host_e_ready = 1'b1;
  assign host_d_sink  = 1'b0;

  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    source_d        = source_q;
    op_d            = op_q;
    base_d          = base_q;
    last_d          = last_q;
    beat_d          = beat_q;
    req_done_d      = req_done_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    host_a_ready    = 1'b0;
    rom_req_o       = 1'b0;
    rom_addr_o      = base_q + RomAddrWidth'(beat_q);
    buf_out_rdy     = 1'b0;
    host_d_valid    = 1'b0;
    host_d_opcode   = D_ACCESS_ACK_DATA;
    host_d_param    = 2'd0;
    host_d_size     = size_q;
    host_d_source   = source_q;
    host_d_denied   = 1'b0;
    host_d_corrupt  = 1'b0;
    host_d_data     = buf_out_data;

    unique case (state_q)
      ST_IDLE: begin
        host_a_ready = 1'b1;
        if (host_a_valid) begin
          size_d   = host_a_size;
          source_d = host_a_source;
          op_d     = host_a_opcode;
          last_d   = a_last_idx;
          beat_d   = BeatWidth'(1);
          if (host_a_opcode == A_GET) begin
            // First word is fetched in the accept cycle to hit the 2-cycle latency.
            base_d          = host_a_address[LgBytes +: RomAddrWidth];
            rom_req_o       = 1'b1;
            rom_addr_o      = host_a_address[LgBytes +: RomAddrWidth];
            inflight_d      = 1'b1;
            inflight_last_d = (a_last_idx == '0);
            req_done_d      = (a_last_idx == '0);
            state_d         = ST_READ;
          end else if (host_a_opcode == A_INTENT) begin
            beat_d  = '0;
            state_d = ST_ERR;
          end else if (host_a_opcode <= A_LOGICAL) begin
            if (a_last_idx == '0) begin
              beat_d  = '0;
              state_d = ST_ERR;
            end else begin
              state_d = ST_SINK;
            end
          end
        end
      end
      ST_READ: begin
        buf_out_rdy  = host_d_ready;
        host_d_valid = buf_out_vld;
        // A pop this cycle frees a slot before the new word lands, keeping 1 beat/cycle.
        if (!req_done_q && (used < 3'd2 + {2'b0, pop})) begin
          rom_req_o       = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (beat_q == last_q);
          req_done_d      = (beat_q == last_q);
          beat_d          = beat_q + BeatWidth'(1);
        end
        if (pop && buf_out_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_SINK: begin
        host_a_ready = 1'b1;
        if (host_a_valid) begin
          beat_d = beat_q + BeatWidth'(1);
          if (beat_q == last_q) begin
            beat_d  = '0;
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        host_d_valid = 1'b1;
        host_d_data  = '0;
        if (op_q == A_INTENT) begin
          host_d_opcode = D_HINT_ACK;
        end else if (op_q == A_ARITH || op_q == A_LOGICAL) begin
          host_d_denied  = 1'b1;
          host_d_corrupt = 1'b1;
        end else begin
          host_d_opcode = D_ACCESS_ACK;
          host_d_denied = 1'b1;
        end
        if (host_d_ready) begin
          beat_d = beat_q + BeatWidth'(1);
          if (beat_q == err_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      size_q          <= '0;
      source_q        <= '0;
      op_q            <= '0;
      base_q          <= '0;
      last_q          <= '0;
      beat_q          <= '0;
      req_done_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      source_q        <= source_d;
      op_q            <= op_d;
      base_q          <= base_d;
      last_q          <= last_d;
      beat_q          <= beat_d;
      req_done_q      <= req_done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  logic [AddrWidth-1:0] a_align_mask;
  logic                 unused_sig;
  assign a_align_mask = AddrWidth'((64'd1 << host_a_size) - 64'd1);
  assign unused_sig   = ^{host_a_param, host_a_mask, host_a_corrupt, host_a_data,
                          host_a_address, buf_in_rdy, a_align_mask};

  a_legal_op: assert property (@(posedge clk_i) disable iff (rst_i)
    (host_a_valid && host_a_ready) |->
      (host_a_opcode != A_ACQUIRE_BLOCK && host_a_opcode != A_ACQUIRE_PERM));
  a_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    (host_a_valid && host_a_ready && state_q == ST_IDLE) |->
      ((host_a_address & a_align_mask) == '0));
  rom_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rom_req_o |-> !(buf_occ == 2'd2 && !pop));

endmodule
